mem_arbiter: RTL

- Shares one variable-latency external memory port between the pipeline's instruction-fetch requester and its data-memory (M-stage) requester.
- Sequences each transaction through request, grant and response phases, with one transaction outstanding at a time.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Generates the fetch and memory-stage stall signals consumed by the hazard unit.
- Data accesses win by default; a starvation counter guarantees fetch progress.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the
// external memory port.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            f_req;
  logic [AW-1:0]   f_addr;
  logic            flush_f;
  logic            f_ack;
  logic [DW-1:0]   f_rdata;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_be;
  logic            d_ack;
  logic [DW-1:0]   d_rdata;

  logic            stall_f;
  logic            stall_m;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  f_req, f_addr, flush_f,
    output f_ack, f_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata,
    output stall_f, stall_m,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport master (
    output f_req, f_addr, flush_f,
    input  f_ack, f_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata,
    input  stall_f, stall_m,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of one variable-latency memory port:
// one transaction in flight, data-first with bounded fetch starvation.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4,
  parameter int CW         = 3
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic          own_q, own_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] stv_q, stv_d;

  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [DW-1:0] f_rdata_q, f_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  logic idle;
  logic starved;
  logic f_win;
  logic d_win;
  logic f_busy;
  logic flush_hit;
  logic cap;
  logic mem_req;
  logic f_ack;
  logic d_ack;

  assign idle    = (state_q == IDLE);
  assign starved = (stv_q == CW'(MAX_STARVE));

  assign f_win = idle & bus.f_req & ~bus.flush_f
               & (~bus.d_req | starved);
  assign d_win = idle & ~f_win & bus.d_req;

  // own_q = 1 means the data side owns the transaction
  assign f_busy    = ((state_q == REQ) | (state_q == WAIT)) & ~own_q;
  assign flush_hit = f_busy & bus.flush_f;
  assign cap       = (state_q == WAIT) & bus.mem_rvalid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (f_win | d_win) state_d = REQ;
      REQ:  if (bus.mem_gnt) state_d = WAIT;
      WAIT: if (bus.mem_rvalid) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d       = own_q;
    drop_d      = drop_q;
    stv_d       = stv_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    f_rdata_d   = f_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (1'b1)
      f_win: begin
        own_d       = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.f_addr;
        mem_wdata_d = '0;
        mem_be_d    = '1;
        stv_d       = '0;
      end
      d_win: begin
        own_d       = 1'b1;
        mem_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        mem_be_d    = bus.d_be;
        if (bus.f_req && (stv_q < CW'(MAX_STARVE))) begin
          stv_d = stv_q + CW'(1);
        end
      end
      default: ;
    endcase

    if (flush_hit) drop_d = 1'b1;
    if (state_q == RESP) drop_d = 1'b0;

    // a flush arriving with the response still discards it
    if (cap && own_q) begin
      d_rdata_d = bus.mem_rdata;
    end
    if (cap && !own_q && !drop_q && !flush_hit) begin
      f_rdata_d = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_q       <= 1'b0;
      drop_q      <= 1'b0;
      stv_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      f_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      own_q       <= own_d;
      drop_q      <= drop_d;
      stv_q       <= stv_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    mem_req = (state_q == REQ);
    f_ack   = (state_q == RESP) & ~own_q & ~drop_q;
    d_ack   = (state_q == RESP) & own_q;
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.f_ack   = f_ack;
  assign bus.d_ack   = d_ack;
  assign bus.f_rdata = f_rdata_q;
  assign bus.d_rdata = d_rdata_q;

  assign bus.stall_f = bus.f_req & ~f_ack;
  assign bus.stall_m = bus.d_req & ~d_ack;
endmodule
